led_display_receiver: RTL
=========================

Name: led_display_receiver

Overview:
- Receive-side model of the LED matrix panel interface: samples bit_clk, rgb_top/rgb_bot, latch enable, output enable and row address exactly as a panel would.
- Rebuilds each shifted row in a capture buffer and commits it on latch.
- Exposes the committed row through a registered read port with status flags.
- Used as a loopback checker behind the display driver in FPGA self-test and as the scoreboard front-end in the driver bench.

Parameters:
NUM_COLS, 64, columns per row, i.e. bit_clk edges per full row
ADDR_W, 3, row address width
COL_W, $clog2(NUM_COLS+1), column index/count width (derived, not overridden)

Ports:
clk_in  input  1  system clock
reset_in  input  1  synchronous active-high reset
bit_clk_in  input  1  panel shift clock, asynchronous to clk_in
rgb_top_in  input  3  top-half RGB bits, panel-sampled on bit_clk rising
rgb_bot_in  input  3  bottom-half RGB bits, panel-sampled on bit_clk rising
latch_enable_in  input  1  row latch; commit on rising edge
output_enable_in  input  1  panel output enable level
addr_in  input  ADDR_W  row address
row_valid_out  output  1  one-cycle pulse when a row is committed
row_addr_out  output  ADDR_W  addr_in sampled at commit
row_count_out  output  COL_W  bit_clk edges captured for the committed row, saturates at NUM_COLS
row_short_out  output  1  committed row had fewer than NUM_COLS edges
row_overflow_out  output  1  committed row had more than NUM_COLS edges
row_oe_out  output  1  output_enable_in level sampled at commit
frame_done_out  output  1  pulse together with row_valid_out when row_addr_out is all ones
rd_col_in  input  COL_W  committed-row read column
rd_top_out  output  3  committed top RGB at rd_col_in
rd_bot_out  output  3  committed bottom RGB at rd_col_in

Behaviour:
- Clock and reset: single clock clk_in; reset_in is synchronous and active-high.
- Reset: all outputs 0, capture/committed buffers cleared, column index 0, sync/edge flops 0.
  - Reset mid-row discards the partial capture.
- Input path: all of bit_clk_in, rgb_*, latch_enable_in, output_enable_in, addr_in pass through identical stages so data stays aligned with the edges.
  - Edge detect = current stage high AND previous stage low.
  - bit_clk_in and latch_enable_in must each be high and low for at least 3 clk_in cycles; narrower pulses are not guaranteed to be seen.
- Capture on a detected bit_clk rise:
  - If index < NUM_COLS: write {rgb_top,rgb_bot} to capture[index]; index++.
  - Otherwise: data dropped, overflow flag set.
- Column order: the first edge after a latch is column 0.
- Commit on a detected latch rise, single registered cycle:
  - committed <= capture; row_count_out <= index.
  - row_short_out <= (index < NUM_COLS); row_overflow_out <= overflow flag.
  - row_addr_out/row_oe_out <= sampled addr/OE.
  - row_valid_out = 1 for that cycle.
  - Then capture cleared to 0, index and overflow flag cleared.
  - Columns not shifted in read back as 0.
- Simultaneous bit_clk rise and latch rise in the same cycle: the bit is captured into the row being committed (merged into the commit), and the new row starts empty.
- Consecutive latches with no bit_clk: commits a row with count 0, short = 1.
- Status outputs hold their value until the next commit. row_valid_out and frame_done_out are pulses.
- Read port:
  - rd_top_out/rd_bot_out are registered, 1-cycle latency.
  - rd_col_in >= NUM_COLS returns 0.
  - A read in the commit cycle returns the old row; the new row is visible from the next cycle.
- Latency with LED_RX_SYNC_EN: row_valid_out asserts in the 4th cycle after the clk_in edge that first samples latch_enable_in high (2 sync + edge + commit register).

Optional Feature:
LED_RX_SYNC_EN
- Defined: 2-flop synchronizer on every input, then the edge-detect flop. Latch-to-row_valid latency is 4 cycles.
- Undefined: single input register, then the edge-detect flop. Latency is 3 cycles, and inputs must already be synchronous to clk_in (on-chip loopback from the driver).
- Capture and commit behaviour is otherwise identical.

Test Plan:
- 64 bit_clk pulses, column k top=k[2:0], bot=~k[2:0], then latch with addr=5 -> one row_valid, row_addr=5, count=64, short=0, overflow=0; rd_col=9 gives top=3'b001, bot=3'b110 one cycle later.
- 40 pulses of top=3'b111, then latch -> count=40, short=1; rd_col 0..39 top=7, rd_col 40..63 top=0.
- 70 pulses, then latch -> count=64, overflow=1; columns 0..63 hold the first 64 values.
- bit_clk rise and latch rise landing in the same clk_in cycle after 63 prior pulses -> count=64, short=0, and the 64th value is present at col 63.
- Rows addr 0..7 each latched -> eight row_valid pulses, frame_done only with addr=7; OE held 0 during the addr=3 latch gives row_oe_out=0 for that row.
- reset_in for 1 cycle after 20 pulses, then 64 pulses and latch -> count=64, no residue from the first 20; all outputs 0 during reset.

Source files
------------

// File: rtl/led_display_receiver.sv
// rtl/led_display_receiver.sv - LED panel receive model: captures shifted rows, commits on latch, registered read port.
// Optional LED_RX_SYNC_EN: 2-flop synchronizer per input instead of a single input register.
module led_display_receiver #(
    parameter int NUM_COLS = 64,
    parameter int ADDR_W   = 3,
    localparam int COL_W   = $clog2(NUM_COLS + 1)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              bit_clk_in,
    input  logic [2:0]        rgb_top_in,
    input  logic [2:0]        rgb_bot_in,
    input  logic              latch_enable_in,
    input  logic              output_enable_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              row_valid_out,
    output logic [ADDR_W-1:0] row_addr_out,
    output logic [COL_W-1:0]  row_count_out,
    output logic              row_short_out,
    output logic              row_overflow_out,
    output logic              row_oe_out,
    output logic              frame_done_out,
    input  logic [COL_W-1:0]  rd_col_in,
    output logic [2:0]        rd_top_out,
    output logic [2:0]        rd_bot_out
);
    localparam int IN_W   = 9 + ADDR_W;
    localparam int CIDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
`ifdef LED_RX_SYNC_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    // Every input travels the same pipeline so data stays aligned with detected edges.
    logic [IN_W-1:0] in_bus;
    logic [IN_W-1:0] stage_q [STAGES];
    logic [IN_W-1:0] cur_q;
    logic            bclk_prev_q, le_prev_q;

    assign in_bus = {bit_clk_in, latch_enable_in, output_enable_in, rgb_top_in, rgb_bot_in, addr_in};

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
            cur_q       <= '0;
            bclk_prev_q <= 1'b0;
            le_prev_q   <= 1'b0;
        end else begin
            stage_q[0] <= in_bus;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
            cur_q       <= stage_q[STAGES-1];
            bclk_prev_q <= cur_q[IN_W-1];
            le_prev_q   <= cur_q[IN_W-2];
        end
    end

    logic              bit_rise, latch_rise, cur_oe;
    logic [5:0]        cur_px;
    logic [ADDR_W-1:0] cur_addr;

    assign bit_rise   = cur_q[IN_W-1] & ~bclk_prev_q;
    assign latch_rise = cur_q[IN_W-2] & ~le_prev_q;
    assign cur_oe     = cur_q[IN_W-3];
    assign cur_px     = cur_q[ADDR_W+5:ADDR_W];
    assign cur_addr   = cur_q[ADDR_W-1:0];

    logic [5:0]        cap_q [NUM_COLS];
    logic [5:0]        cap_d [NUM_COLS];
    logic [5:0]        com_q [NUM_COLS];
    logic [5:0]        com_d [NUM_COLS];
    logic [COL_W-1:0]  idx_q, idx_d, count_q, count_d;
    logic              ovf_q, ovf_d, valid_q, valid_d, frame_q, frame_d;
    logic              short_q, short_d, rovf_q, rovf_d, oe_q, oe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        rd_q, rd_d;

    always_comb begin
        cap_d   = cap_q;
        com_d   = com_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        short_d = short_q;
        rovf_d  = rovf_q;
        oe_d    = oe_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        frame_d = 1'b0;
        rd_d    = 6'd0;

        if (bit_rise) begin
            if (idx_q < COL_W'(NUM_COLS)) begin
                cap_d[idx_q[CIDX_W-1:0]] = cur_px;
                idx_d = idx_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        // Commit sees the post-capture view, so a coincident bit lands in the committed row.
        if (latch_rise) begin
            com_d   = cap_d;
            count_d = idx_d;
            short_d = (idx_d < COL_W'(NUM_COLS));
            rovf_d  = ovf_d;
            addr_d  = cur_addr;
            oe_d    = cur_oe;
            valid_d = 1'b1;
            frame_d = &cur_addr;
            for (int i = 0; i < NUM_COLS; i++) cap_d[i] = 6'd0;
            idx_d   = '0;
            ovf_d   = 1'b0;
        end

        if (rd_col_in < COL_W'(NUM_COLS)) rd_d = com_q[rd_col_in[CIDX_W-1:0]];
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                cap_q[i] <= 6'd0;
                com_q[i] <= 6'd0;
            end
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            short_q <= 1'b0;
            rovf_q  <= 1'b0;
            oe_q    <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            rd_q    <= 6'd0;
        end else begin
            cap_q   <= cap_d;
            com_q   <= com_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            short_q <= short_d;
            rovf_q  <= rovf_d;
            oe_q    <= oe_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            rd_q    <= rd_d;
        end
    end

    assign row_valid_out    = valid_q;
    assign row_addr_out     = addr_q;
    assign row_count_out    = count_q;
    assign row_short_out    = short_q;
    assign row_overflow_out = rovf_q;
    assign row_oe_out       = oe_q;
    assign frame_done_out   = frame_q;
    assign rd_top_out       = rd_q[5:3];
    assign rd_bot_out       = rd_q[2:0];
endmodule
